// File: rtl/uart_pkg.sv
// Shared encodings for the configurable UART: parity modes, FSM states, divisor floor.
package uart_pkg;

  localparam logic [2:0] PAR_NONE  = 3'd0;
  localparam logic [2:0] PAR_EVEN  = 3'd1;
  localparam logic [2:0] PAR_ODD   = 3'd2;
  localparam logic [2:0] PAR_MARK  = 3'd3;
  localparam logic [2:0] PAR_SPACE = 3'd4;

  localparam int unsigned MIN_DIV = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } state_t;

  // Undefined parity codes behave as no parity.
  function automatic logic [2:0] norm_par(input logic [2:0] mode);
    return (mode > PAR_SPACE) ? PAR_NONE : mode;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Loadable bit-period down-counter; tick marks the last cycle of each bit period.
module uart_baud_gen #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  // Reloads on restart or when a period expires, so periods never drift.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (restart || cnt == '0) begin
      cnt <= div - DIV_W'(1);
    end else begin
      cnt <= cnt - DIV_W'(1);
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter with one-entry holding register and line break.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned MAX_DATA_BITS = 9,
  parameter int unsigned DIV_W         = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DIV_W-1:0]         baud_div,
  input  logic [3:0]               nbits,
  input  logic [2:0]               par_mode,
  input  logic                     stop2,
  input  logic                     brk,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [MAX_DATA_BITS-1:0] din,
  output logic                     tx,
  output logic                     busy
);

  localparam int unsigned NB_W = 4;

  state_t                   state_q, state_d;
  logic                     tx_d, in_ready_d, busy_d;
  logic [MAX_DATA_BITS-1:0] hold_q, hold_d;
  logic [MAX_DATA_BITS-1:0] shift_q, shift_d;
  logic [NB_W-1:0]          bit_cnt_q, bit_cnt_d;
  logic                     stop_cnt_q, stop_cnt_d;
  logic [DIV_W-1:0]         div_q, div_d;
  logic [NB_W-1:0]          nbits_q, nbits_d;
  logic [2:0]               par_q, par_d;
  logic                     stop2_q, stop2_d;
  logic                     par_bit_q, par_bit_d;
  logic                     mab_q, mab_d;

  logic                     tick, restart, start_frame, mab_restart;
  logic [DIV_W-1:0]         div_clamped, baud_sel;
  logic [NB_W-1:0]          nbits_clamped;
  logic [2:0]               par_norm;
  logic                     data_xor, par_bit_new;

  // Configuration as it would be latched by a frame starting this cycle.
  always_comb begin
    div_clamped   = (baud_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : baud_div;
    nbits_clamped = (nbits < NB_W'(5)) ? NB_W'(5) :
                    (nbits > NB_W'(MAX_DATA_BITS)) ? NB_W'(MAX_DATA_BITS) : nbits;
    par_norm      = norm_par(par_mode);
    data_xor      = 1'b0;
    for (int i = 0; i < MAX_DATA_BITS; i++) begin
      if (NB_W'(i) < nbits_clamped) data_xor = data_xor ^ hold_q[i];
    end
    case (par_norm)
      PAR_EVEN: par_bit_new = data_xor;
      PAR_ODD:  par_bit_new = ~data_xor;
      PAR_MARK: par_bit_new = 1'b1;
      default:  par_bit_new = 1'b0;
    endcase
  end

  assign restart  = start_frame | mab_restart;
  assign baud_sel = restart ? div_clamped : div_q;

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .div     (baud_sel),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      tx         <= 1'b1;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
      hold_q     <= '0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      div_q      <= DIV_W'(MIN_DIV);
      nbits_q    <= NB_W'(5);
      par_q      <= PAR_NONE;
      stop2_q    <= 1'b0;
      par_bit_q  <= 1'b0;
      mab_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx         <= tx_d;
      in_ready   <= in_ready_d;
      busy       <= busy_d;
      hold_q     <= hold_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      div_q      <= div_d;
      nbits_q    <= nbits_d;
      par_q      <= par_d;
      stop2_q    <= stop2_d;
      par_bit_q  <= par_bit_d;
      mab_q      <= mab_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tx_d        = tx;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    div_d       = div_q;
    nbits_d     = nbits_q;
    par_d       = par_q;
    stop2_d     = stop2_q;
    par_bit_d   = par_bit_q;
    mab_d       = mab_q;
    hold_d      = hold_q;
    in_ready_d  = in_ready;
    start_frame = 1'b0;
    mab_restart = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (mab_q && tick) mab_d = 1'b0;
        if (brk) begin
          state_d = ST_BREAK;
          tx_d    = 1'b0;
          mab_d   = 1'b0;
        end else if (!in_ready && (!mab_q || tick)) begin
          start_frame = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d   = ST_DATA;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_cnt_q == nbits_q - NB_W'(1)) begin
            if (par_q != PAR_NONE) begin
              state_d = ST_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d    = ST_STOP;
              tx_d       = 1'b1;
              stop_cnt_d = 1'b0;
            end
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + NB_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d    = ST_STOP;
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else if (!in_ready && !brk) begin
            start_frame = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_BREAK: begin
        tx_d = 1'b0;
        // Release restarts the bit timer to guarantee a mark period before any start.
        if (!brk) begin
          state_d     = ST_IDLE;
          tx_d        = 1'b1;
          mab_d       = 1'b1;
          mab_restart = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (start_frame) begin
      state_d   = ST_START;
      tx_d      = 1'b0;
      shift_d   = hold_q;
      bit_cnt_d = '0;
      div_d     = div_clamped;
      nbits_d   = nbits_clamped;
      par_d     = par_norm;
      stop2_d   = stop2;
      par_bit_d = par_bit_new;
    end

    // Accept wins over unload so a same-edge refill keeps the register full.
    if (in_valid && in_ready) begin
      hold_d     = din;
      in_ready_d = 1'b0;
    end else if (start_frame) begin
      in_ready_d = 1'b1;
    end

    busy_d = (state_d != ST_IDLE) | ~in_ready_d;
  end

endmodule
